// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared combinational ALU for its additions.
// Produces the low WIDTH bits of op_a*op_b; the ALU bus is parked on PASS whenever busy is low.
module alu_mul_seq #(
    parameter int          WIDTH      = 32,
    parameter logic [4:0]  ALU_ADD    = 5'b00001,
    parameter logic [4:0]  ALU_PASS   = 5'b00100,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_c,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: start is a level sampled only in IDLE/DONE; busy marks RUN,
    // done is a single-cycle pulse and result stays valid until the next done.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_acc_step;
    logic             w_last;
    logic             w_accept;

    // Last iteration: counter exhausted, or no multiplier bits remain after this one.
    assign w_last     = (r_cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && ((r_q >> 1) == '0));
    assign w_acc_step = r_q[0] ? alu_c : r_acc;
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_next_state = r_state;
        alu_a        = '0;
        alu_b        = '0;
        alu_ctrl     = ALU_PASS;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                alu_a    = r_acc;
                alu_b    = r_m;
                alu_ctrl = ALU_ADD;
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = start ? S_RUN : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_acc <= '0;
                r_m   <= op_a;
                r_q   <= op_b;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_step;
                r_m   <= r_m << 1;
                r_q   <= r_q >> 1;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) r_result <= w_acc_step;
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed vector table, corner sequences and a
// randomized run against an arithmetic reference model with a behavioural shared ALU.
module tb_alu_mul_seq;

    localparam int         W      = 32;
    localparam logic [4:0] C_ADD  = 5'b00001;
    localparam logic [4:0] C_PASS = 5'b00100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [4:0]    alu_ctrl;
    logic [W-1:0]  alu_c;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           exp_n;
    } vec_t;

    vec_t vecs[7];

    alu_mul_seq #(.WIDTH(W), .ALU_ADD(C_ADD), .ALU_PASS(C_PASS), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_c(alu_c),
        .dbg_state(dbg_state)
    );

    // Shared ALU stand-in.
    assign alu_c = (alu_ctrl == C_ADD)  ? alu_a + alu_b :
                   (alu_ctrl == C_PASS) ? alu_a : '0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, expv);
        end
    endtask

    function automatic int model_n(input logic [W-1:0] b);
        int n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    // Presents an operation and clocks the accepting edge; leaves the DUT in its first RUN cycle.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back(model_mul(a, b));
        tick();
        start = 1'b0;
    endtask

    // Counts RUN cycles until done; optionally disturbs start/op_a/op_b mid-run.
    task automatic finish_op(input string name, input int exp_n, input bit disturb);
        int n = 0;
        logic [W-1:0] expv;
        bit ctrl_ok = 1'b1;
        while (busy && n < 200) begin
            if (alu_ctrl !== C_ADD) ctrl_ok = 1'b0;
            if (disturb) begin
                start = (n == 1);
                op_a  = $urandom;
                op_b  = $urandom;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({name, " alu_ctrl in RUN"}, {31'd0, ctrl_ok}, 32'd1);
        check({name, " run cycles"}, n, exp_n);
        check({name, " done"}, {31'd0, done}, 32'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({name, " result"}, result, expv);
        check({name, " alu_ctrl idle"}, {27'd0, alu_ctrl}, {27'd0, C_PASS});
    endtask

    task automatic go_idle(input string name, input logic [W-1:0] held);
        tick();
        check({name, " done drop"}, {31'd0, done}, 32'd0);
        check({name, " busy idle"}, {31'd0, busy}, 32'd0);
        check({name, " result held"}, result, held);
    endtask

    initial begin
        vecs[0] = '{32'd3,         32'd5,         32'd15,        3};
        vecs[1] = '{32'h12345678,  32'd0,         32'd0,         1};
        vecs[2] = '{32'd0,         32'h80000000,  32'd0,         32};
        vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32};
        vecs[4] = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFD6,  3};
        vecs[5] = '{32'd1,         32'd1,         32'd1,         1};
        vecs[6] = '{32'd7,         32'h00010000,  32'h00070000,  17};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset alu_ctrl", {27'd0, alu_ctrl}, {27'd0, C_PASS});
        check("reset alu_a", alu_a, 32'd0);
        tick();

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b);
            // Table constants are the authority; the queued model value must agree.
            exp_q[exp_q.size()-1] = vecs[i].exp_res;
            finish_op($sformatf("vec%0d", i), vecs[i].exp_n, 1'b0);
            go_idle($sformatf("vec%0d", i), vecs[i].exp_res);
        end

        // Mid-run start pulse and operand changes must be ignored.
        launch(32'd3, 32'h000000F0);
        finish_op("disturb", 8, 1'b1);
        // Restart straight from the DONE cycle.
        launch(32'd9, 32'd11);
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b done", {31'd0, done}, 32'd0);
        finish_op("b2b", 4, 1'b0);
        go_idle("b2b", 32'd99);

        // Reset in the third RUN cycle.
        launch(32'h11, 32'hFF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_front());
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid done", {31'd0, done}, 32'd0);
        check("rst mid result", result, 32'd0);
        check("rst mid alu_ctrl", {27'd0, alu_ctrl}, {27'd0, C_PASS});
        // start together with reset: reset wins.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", {31'd0, busy}, 32'd0);
        tick();
        launch(32'd6, 32'd7);
        finish_op("after rst", 3, 1'b0);
        go_idle("after rst", 32'd42);

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = '0;
            launch(a, b);
            finish_op("rand", model_n(b), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) go_idle("rand", model_mul(a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
